// File: rtl/pattern_stream_gen.sv
// rtl/pattern_stream_gen.sv - multi-mode raster test-pattern source on a valid/ready pixel stream
module pattern_stream_gen #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int B_WIDTH    = 10,
  parameter int B_HEIGHT   = 9,
  parameter int B_VGA      = 4,
  parameter int CHECK_LOG2 = 3
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 init_i,
  input  logic                 fclock_i,
  input  logic [1:0]           mode_i,
  input  logic [3*B_VGA-1:0]   color_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [B_WIDTH-1:0]   xout_o,
  output logic [B_HEIGHT-1:0]  yout_o,
  output logic [3*B_VGA-1:0]   rgbout_o,
  output logic                 sof_o,
  output logic                 eol_o,
  output logic                 eof_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic [15:0]          frames_o
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} state_t;

  state_t                state_q;
  logic                  init_q;
  logic [1:0]            mode_q;
  logic [3*B_VGA-1:0]    color_q;
  logic [B_WIDTH-1:0]    x_q, x_d;
  logic [B_HEIGHT-1:0]   y_q, y_d;
  logic                  valid_q, sof_q, eol_q, eof_q, overrun_q;
  logic [3*B_VGA-1:0]    rgb_q;
  logic [15:0]           frames_q;
  logic                  eol_d, eof_d;

  // Gradient level is x left-justified into B_VGA bits, so narrow rasters still span the range.
  function automatic logic [3*B_VGA-1:0] pixel_rgb(input logic [1:0] m,
                                                   input logic [3*B_VGA-1:0] c,
                                                   input logic [B_WIDTH-1:0] x,
                                                   input logic ybit);
    logic [B_VGA-1:0]   g;
    logic [2:0]         b;
    logic [3*B_VGA-1:0] r;
    g = B_VGA'({x, {B_VGA{1'b0}}} >> B_WIDTH);
    b = x[B_WIDTH-1 -: 3];
    case (m)
      2'd0: r = c;
      2'd1: r = {(|c[3*B_VGA-1 -: B_VGA]) ? g : {B_VGA{1'b0}},
                 (|c[2*B_VGA-1 -: B_VGA]) ? g : {B_VGA{1'b0}},
                 (|c[B_VGA-1:0])          ? g : {B_VGA{1'b0}}};
      2'd2: r = {{B_VGA{b[2]}}, {B_VGA{b[1]}}, {B_VGA{b[0]}}};
      // The square at the origin carries the foreground colour.
      default: r = (x[CHECK_LOG2] == ybit) ? c : {3*B_VGA{1'b0}};
    endcase
    return r;
  endfunction

  always_comb begin
    x_d = x_q + 1'b1;
    y_d = y_q;
    if (x_q == B_WIDTH'(WIDTH - 1)) begin
      x_d = '0;
      y_d = y_q + 1'b1;
    end
    eol_d = (x_d == B_WIDTH'(WIDTH - 1));
    eof_d = eol_d && (y_d == B_HEIGHT'(HEIGHT - 1));
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      init_q    <= 1'b0;
      mode_q    <= '0;
      color_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      overrun_q <= 1'b0;
      rgb_q     <= '0;
      frames_q  <= '0;
    end else begin
      init_q    <= init_i;
      overrun_q <= (state_q == S_RUN) && fclock_i;
      case (state_q)
        S_IDLE: begin
          if (init_i && !init_q) state_q <= S_ARMED;
        end
        S_ARMED: begin
          if (fclock_i) begin
            state_q <= S_RUN;
            mode_q  <= mode_i;
            color_q <= color_i;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b1;
            sof_q   <= 1'b1;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            rgb_q   <= pixel_rgb(mode_i, color_i, '0, 1'b0);
          end
        end
        S_RUN: begin
          if (valid_q && ready_i) begin
            if (eof_q) begin
              valid_q  <= 1'b0;
              sof_q    <= 1'b0;
              eol_q    <= 1'b0;
              eof_q    <= 1'b0;
              frames_q <= frames_q + 16'd1;
              state_q  <= init_i ? S_ARMED : S_IDLE;
            end else begin
              x_q   <= x_d;
              y_q   <= y_d;
              sof_q <= 1'b0;
              eol_q <= eol_d;
              eof_q <= eof_d;
              rgb_q <= pixel_rgb(mode_q, color_q, x_d, y_d[CHECK_LOG2]);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign valid_o   = valid_q;
  assign xout_o    = x_q;
  assign yout_o    = y_q;
  assign rgbout_o  = rgb_q;
  assign sof_o     = sof_q;
  assign eol_o     = eol_q;
  assign eof_o     = eof_q;
  assign busy_o    = (state_q == S_RUN);
  assign overrun_o = overrun_q;
  assign frames_o  = frames_q;

endmodule

// File: tb/tb_pattern_stream_gen.sv
// tb/tb_pattern_stream_gen.sv - self-checking bench for pattern_stream_gen (8x4 raster)
module tb_pattern_stream_gen;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int BW = 3;
  localparam int BH = 2;
  localparam int BV = 4;
  localparam int CL = 1;

  logic            clock_i = 1'b0;
  logic            reset_n_i, init_i, fclock_i, ready_i;
  logic [1:0]      mode_i;
  logic [11:0]     color_i;
  logic            valid_o, sof_o, eol_o, eof_o, busy_o, overrun_o;
  logic [BW-1:0]   xout_o;
  logic [BH-1:0]   yout_o;
  logic [11:0]     rgbout_o;
  logic [15:0]     frames_o;

  int errors = 0;
  int checks = 0;
  int frames_exp = 0;

  pattern_stream_gen #(
    .WIDTH(W), .HEIGHT(H), .B_WIDTH(BW), .B_HEIGHT(BH), .B_VGA(BV), .CHECK_LOG2(CL)
  ) dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .init_i(init_i), .fclock_i(fclock_i),
    .mode_i(mode_i), .color_i(color_i), .ready_i(ready_i), .valid_o(valid_o),
    .xout_o(xout_o), .yout_o(yout_o), .rgbout_o(rgbout_o), .sof_o(sof_o), .eol_o(eol_o),
    .eof_o(eof_o), .busy_o(busy_o), .overrun_o(overrun_o), .frames_o(frames_o)
  );

  always #5 clock_i = ~clock_i;

  // Reference colour of pixel (x,y) derived from the pattern rules with plain arithmetic.
  function automatic logic [11:0] exp_rgb(input int m, input logic [11:0] c, input int x, input int y);
    int g;
    logic [3:0] gv;
    logic [3:0] r, gr, b;
    g  = x * (1 << BV) / W;
    gv = g[3:0];
    case (m)
      0: return c;
      1: begin
        r  = (c[11:8] != 0) ? gv : 4'h0;
        gr = (c[7:4]  != 0) ? gv : 4'h0;
        b  = (c[3:0]  != 0) ? gv : 4'h0;
        return {r, gr, b};
      end
      2: begin
        r  = (x >= 4)          ? 4'hF : 4'h0;
        gr = (((x / 2) % 2) == 1) ? 4'hF : 4'h0;
        b  = ((x % 2) == 1)    ? 4'hF : 4'h0;
        return {r, gr, b};
      end
      default: return (((x / 2) % 2) == ((y / 2) % 2)) ? c : 12'h000;
    endcase
  endfunction

  // Streams one frame from ARMED; rdy_pat 0=always, 1=toggle, 2=random.
  task automatic stream_frame(input logic [1:0] m, input logic [11:0] c, input int rdy_pat,
                              input bit hold, input bit scramble, input int drop_init_at,
                              output int accepts);
    int k, n, ex, ey;
    bit done;
    logic [2:0] ef;
    mode_i = m; color_i = c; fclock_i = 1'b1; ready_i = 1'b1;
    k = 0; n = 0; done = 0; accepts = 0;
    while (!done && n < 400) begin
      @(negedge clock_i);
      n++;
      if (!hold) fclock_i = 1'b0;
      if (scramble) begin mode_i = 2'($urandom); color_i = 12'($urandom); end
      checks++;
      if (overrun_o !== ((n >= 2) && hold)) begin
        errors++; $display("FAIL overrun n=%0d: got %b want %b", n, overrun_o, (n >= 2) && hold);
      end
      if (n == 1) begin
        checks++;
        if (valid_o !== 1'b1) begin errors++; $display("FAIL valid_rise: got %b want 1", valid_o); end
      end
      case (rdy_pat)
        0: ready_i = 1'b1;
        1: ready_i = (n % 2) == 0;
        default: ready_i = 1'($urandom);
      endcase
      if (valid_o) begin
        ex = k % W; ey = k / W;
        ef = {k == 0, ex == W - 1, k == W * H - 1};
        checks += 5;
        if (xout_o !== BW'(ex)) begin errors++; $display("FAIL xout k=%0d: got %0d want %0d", k, xout_o, ex); end
        if (yout_o !== BH'(ey)) begin errors++; $display("FAIL yout k=%0d: got %0d want %0d", k, yout_o, ey); end
        if (rgbout_o !== exp_rgb(int'(m), c, ex, ey)) begin
          errors++; $display("FAIL rgb k=%0d: got %h want %h", k, rgbout_o, exp_rgb(int'(m), c, ex, ey));
        end
        if ({sof_o, eol_o, eof_o} !== ef) begin
          errors++; $display("FAIL flags k=%0d: got %b want %b", k, {sof_o, eol_o, eof_o}, ef);
        end
        if (busy_o !== 1'b1) begin errors++; $display("FAIL busy k=%0d: got %b want 1", k, busy_o); end
        if (ready_i) begin
          accepts++; k++;
          if (k == W * H) done = 1;
          if (k == drop_init_at) init_i = 1'b0;
        end
      end
    end
    if (!done) begin
      checks++; errors++; $display("FAIL frame_timeout: got %0d beats want %0d", k, W * H);
    end else frames_exp++;
    @(negedge clock_i);
    checks += 4;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL valid_after_eof: got %b want 0", valid_o); end
    if (frames_o !== 16'(frames_exp)) begin errors++; $display("FAIL frames: got %0d want %0d", frames_o, frames_exp); end
    if (overrun_o !== hold) begin errors++; $display("FAIL overrun_eof: got %b want %b", overrun_o, hold); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL busy_after_eof: got %b want 0", busy_o); end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; init_i = 1'b0; fclock_i = 1'b0; ready_i = 1'b0; mode_i = 2'd0; color_i = 12'h0;
    repeat (2) @(negedge clock_i);
    checks += 5;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    if ({xout_o, yout_o} !== '0) begin errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", xout_o, yout_o); end
    if (rgbout_o !== 12'h0) begin errors++; $display("FAIL reset_rgb: got %h want 000", rgbout_o); end
    if ({sof_o, eol_o, eof_o, busy_o, overrun_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {sof_o, eol_o, eof_o, busy_o, overrun_o});
    end
    if (frames_o !== 16'h0) begin errors++; $display("FAIL reset_frames: got %0d want 0", frames_o); end
    reset_n_i = 1'b1;
    @(negedge clock_i);
  endtask

  task automatic test_solid();
    int acc;
    init_i = 1'b1;
    @(negedge clock_i);
    stream_frame(2'd0, 12'hABC, 0, 0, 0, -1, acc);
    checks++;
    if (acc !== 32) begin errors++; $display("FAIL solid_accepts: got %0d want 32", acc); end
  endtask

  task automatic test_stall_bars();
    int acc;
    stream_frame(2'd2, 12'($urandom), 1, 0, 0, -1, acc);
    checks++;
    if (acc !== 32) begin errors++; $display("FAIL stall_accepts: got %0d want 32", acc); end
  endtask

  task automatic test_checker_gradient();
    int acc;
    stream_frame(2'd3, 12'hFFF, 0, 0, 0, -1, acc);
    stream_frame(2'd1, 12'hF00, 0, 0, 0, -1, acc);
  endtask

  task automatic test_random();
    int acc;
    for (int i = 0; i < 6; i++) begin
      stream_frame(2'($urandom), 12'($urandom), 2, 0, 1, -1, acc);
      repeat (int'($urandom_range(0, 2))) @(negedge clock_i);
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    stream_frame(2'($urandom), 12'($urandom), 0, 1, 0, -1, acc);
    stream_frame(2'($urandom), 12'($urandom), 0, 1, 0, 10, acc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_i);
      checks++;
      if ({valid_o, busy_o, overrun_o} !== 3'b000) begin
        errors++; $display("FAIL idle_after_disarm i=%0d: got %b want 000", i, {valid_o, busy_o, overrun_o});
      end
    end
    fclock_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    init_i = 1'b1;
    @(negedge clock_i);
    mode_i = 2'd0; color_i = 12'($urandom); ready_i = 1'b1; fclock_i = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clock_i);
      fclock_i = 1'b0;
      if (valid_o && xout_o == 3'd3 && yout_o == 2'd1) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL reach_3_1: got no pixel (3,1) want one"); end
    reset_n_i = 1'b0; init_i = 1'b0;
    #1;
    frames_exp = 0;
    checks += 2;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b want 0", valid_o); end
    if ({xout_o, yout_o, frames_o} !== '0) begin
      errors++; $display("FAIL async_reset_xyf: got %0d,%0d,%0d want 0,0,0", xout_o, yout_o, frames_o);
    end
    @(negedge clock_i);
    reset_n_i = 1'b1;
    fclock_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock_i);
      checks++;
      if ({valid_o, busy_o} !== 2'b00) begin
        errors++; $display("FAIL no_init_edge i=%0d: got %b want 00", i, {valid_o, busy_o});
      end
    end
    fclock_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_solid();
    test_stall_bars();
    test_checker_gradient();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
